nfc_card_detector: RTL and testbench

ISO14443A card-detection sequencer that sits between the MFRC522 command interface and the authentication block. A rising edge on the reader interrupt starts a REQA → ANTICOLL → SELECT exchange through a single-command handshake. On success it latches the card UID and raises `card_ready`/`start_auth`; on failure it raises `detection_error` with a code.

---
 rtl/nfc_card_detector.sv | 251 +++++++++++++++++++++++++
 tb/tb_nfc_card_detector.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nfc_card_detector.sv
// rtl/nfc_card_detector.sv - ISO14443A REQA/ANTICOLL/SELECT card-detection sequencer
module nfc_card_detector #(
    parameter int CMD_TIMEOUT = 1000,
    parameter int HOLD_CYCLES = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nfc_irq,
    output logic        card_detected,
    output logic [31:0] card_uid,
    output logic        card_ready,
    output logic        start_auth,
    output logic        nfc_cmd_valid,
    input  logic        nfc_cmd_ready,
    output logic        nfc_cmd_write,
    output logic [5:0]  nfc_cmd_addr,
    output logic [7:0]  nfc_cmd_wdata,
    input  logic [7:0]  nfc_cmd_rdata,
    input  logic        nfc_cmd_done,
    output logic        detection_error,
    output logic [7:0]  error_code
);

    // Counter widths only need to reach the last count value (N-1).
    localparam int TW = (CMD_TIMEOUT > 1) ? $clog2(CMD_TIMEOUT) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CMD_TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

    // MFRC522 FIFODataReg; every command byte is written there.
    localparam logic [5:0] FIFO_DATA_ADDR = 6'h09;

    localparam logic [7:0] CMD_REQA     = 8'h26;
    localparam logic [7:0] CMD_ANTICOLL = 8'h93;
    localparam logic [7:0] CMD_SELECT   = 8'h93;

    localparam logic [7:0] ERR_TO_REQA   = 8'h11;
    localparam logic [7:0] ERR_TO_ANTI   = 8'h12;
    localparam logic [7:0] ERR_TO_SEL    = 8'h13;
    localparam logic [7:0] ERR_REQA_RESP = 8'h21;
    localparam logic [7:0] ERR_ANTI_RESP = 8'h22;
    localparam logic [7:0] ERR_SEL_RESP  = 8'h23;
    localparam logic [7:0] ERR_CASCADE   = 8'h24;

    typedef enum logic [3:0] {
        S_IDLE,
        S_REQA_SEND,
        S_REQA_WAIT,
        S_ANTI_SEND,
        S_ANTI_WAIT,
        S_SEL_SEND,
        S_SEL_WAIT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t          r_state;
    logic            r_irq_q;
    logic            r_start_pend;
    logic [TW-1:0]   r_timer;
    logic [HW-1:0]   r_hold;
    logic            r_card_detected;
    logic [7:0]      r_uid_byte;
    logic            r_card_ready;
    logic            r_start_auth;
    logic            r_cmd_valid;
    logic            r_cmd_write;
    logic [7:0]      r_cmd_wdata;
    logic            r_detection_error;
    logic [7:0]      r_error_code;

    logic            w_irq_rise;
    logic            w_timeout;
    logic            w_pass;
    logic            w_fail;
    logic [7:0]      w_fail_code;

    assign w_irq_rise = nfc_irq & ~r_irq_q;
    assign w_timeout  = (r_timer == TIMER_LAST);

    // Verdict for the current WAIT state; a response strobe outranks a coincident timeout.
    always_comb begin
        w_pass      = 1'b0;
        w_fail      = 1'b0;
        w_fail_code = 8'h00;
        case (r_state)
            S_REQA_WAIT: begin
                if (nfc_cmd_done) begin
                    if (nfc_cmd_rdata == 8'hFF || nfc_cmd_rdata == 8'h00) begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_REQA_RESP;
                    end else begin
                        w_pass = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TO_REQA;
                end
            end
            S_ANTI_WAIT: begin
                if (nfc_cmd_done) begin
                    if (nfc_cmd_rdata == 8'hFF) begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_ANTI_RESP;
                    end else begin
                        w_pass = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TO_ANTI;
                end
            end
            S_SEL_WAIT: begin
                if (nfc_cmd_done) begin
                    if (nfc_cmd_rdata == 8'hFF) begin
                        w_fail      = 1'b1;
                        w_fail_code = ERR_SEL_RESP;
                    end else if (nfc_cmd_rdata[2]) begin
                        // SAK cascade bit: a longer UID follows, which this block does not handle.
                        w_fail      = 1'b1;
                        w_fail_code = ERR_CASCADE;
                    end else begin
                        w_pass = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_fail      = 1'b1;
                    w_fail_code = ERR_TO_SEL;
                end
            end
            default: begin
                w_pass      = 1'b0;
                w_fail      = 1'b0;
                w_fail_code = 8'h00;
            end
        endcase
    end

    // Detection sequencer: IRQ edge capture, command handshake, response checks and hold timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_IDLE;
            r_irq_q           <= 1'b0;
            r_start_pend      <= 1'b0;
            r_timer           <= '0;
            r_hold            <= '0;
            r_card_detected   <= 1'b0;
            r_uid_byte        <= 8'h00;
            r_card_ready      <= 1'b0;
            r_start_auth      <= 1'b0;
            r_cmd_valid       <= 1'b0;
            r_cmd_write       <= 1'b0;
            r_cmd_wdata       <= 8'h00;
            r_detection_error <= 1'b0;
            r_error_code      <= 8'h00;
        end else begin
            r_irq_q      <= nfc_irq;
            // The edge is only armed while idle, so IRQ activity mid-sequence is ignored.
            r_start_pend <= (r_state == S_IDLE) && w_irq_rise;

            case (r_state)
                S_IDLE: begin
                    if (r_start_pend) begin
                        r_uid_byte      <= 8'h00;
                        r_error_code    <= 8'h00;
                        r_card_detected <= 1'b1;
                        r_cmd_valid     <= 1'b1;
                        r_cmd_write     <= 1'b1;
                        r_cmd_wdata     <= CMD_REQA;
                        r_state         <= S_REQA_SEND;
                    end
                end

                // Valid is always high in SEND states, so ready alone completes the transfer.
                S_REQA_SEND, S_ANTI_SEND, S_SEL_SEND: begin
                    if (nfc_cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_cmd_write <= 1'b0;
                        r_timer     <= '0;
                        case (r_state)
                            S_REQA_SEND: r_state <= S_REQA_WAIT;
                            S_ANTI_SEND: r_state <= S_ANTI_WAIT;
                            default:     r_state <= S_SEL_WAIT;
                        endcase
                    end
                end

                S_REQA_WAIT, S_ANTI_WAIT, S_SEL_WAIT: begin
                    if (w_fail) begin
                        r_error_code      <= w_fail_code;
                        r_detection_error <= 1'b1;
                        r_hold            <= '0;
                        r_state           <= S_ERROR;
                    end else if (w_pass) begin
                        case (r_state)
                            S_REQA_WAIT: begin
                                r_cmd_valid <= 1'b1;
                                r_cmd_write <= 1'b1;
                                r_cmd_wdata <= CMD_ANTICOLL;
                                r_state     <= S_ANTI_SEND;
                            end
                            S_ANTI_WAIT: begin
                                r_uid_byte  <= nfc_cmd_rdata;
                                r_cmd_valid <= 1'b1;
                                r_cmd_write <= 1'b1;
                                r_cmd_wdata <= CMD_SELECT;
                                r_state     <= S_SEL_SEND;
                            end
                            default: begin
                                r_card_ready <= 1'b1;
                                r_start_auth <= 1'b1;
                                r_hold       <= '0;
                                r_state      <= S_DONE;
                            end
                        endcase
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                // UID and error code survive the return to idle; only the status flags drop.
                S_DONE, S_ERROR: begin
                    if (r_hold == HOLD_LAST) begin
                        r_card_detected   <= 1'b0;
                        r_card_ready      <= 1'b0;
                        r_start_auth      <= 1'b0;
                        r_detection_error <= 1'b0;
                        r_state           <= S_IDLE;
                    end else begin
                        r_hold <= r_hold + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign card_detected   = r_card_detected;
    assign card_uid        = {24'h0, r_uid_byte};
    assign card_ready      = r_card_ready;
    assign start_auth      = r_start_auth;
    assign nfc_cmd_valid   = r_cmd_valid;
    assign nfc_cmd_write   = r_cmd_write;
    assign nfc_cmd_addr    = FIFO_DATA_ADDR;
    assign nfc_cmd_wdata   = r_cmd_wdata;
    assign detection_error = r_detection_error;
    assign error_code      = r_error_code;

endmodule

// File: tb/tb_nfc_card_detector.sv
// tb/tb_nfc_card_detector.sv - scoreboard bench for nfc_card_detector
module tb_nfc_card_detector;

    localparam int CMD_TIMEOUT = 40;
    localparam int HOLD_CYCLES = 8;

    logic        clk;
    logic        rst_n;
    logic        nfc_irq;
    logic        card_detected;
    logic [31:0] card_uid;
    logic        card_ready;
    logic        start_auth;
    logic        nfc_cmd_valid;
    logic        nfc_cmd_ready;
    logic        nfc_cmd_write;
    logic [5:0]  nfc_cmd_addr;
    logic [7:0]  nfc_cmd_wdata;
    logic [7:0]  nfc_cmd_rdata;
    logic        nfc_cmd_done;
    logic        detection_error;
    logic [7:0]  error_code;

    typedef struct {
        int val;
        int lat;
    } resp_t;

    typedef struct {
        bit          is_err;
        logic [7:0]  code;
        logic [31:0] uid;
    } out_t;

    resp_t      resp_q[$];
    logic [7:0] exp_cmd_q[$];
    out_t       exp_out_q[$];

    int checks = 0;
    int errors = 0;
    int n_xfer = 0;

    nfc_card_detector #(
        .CMD_TIMEOUT(CMD_TIMEOUT),
        .HOLD_CYCLES(HOLD_CYCLES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .nfc_irq(nfc_irq),
        .card_detected(card_detected),
        .card_uid(card_uid),
        .card_ready(card_ready),
        .start_auth(start_auth),
        .nfc_cmd_valid(nfc_cmd_valid),
        .nfc_cmd_ready(nfc_cmd_ready),
        .nfc_cmd_write(nfc_cmd_write),
        .nfc_cmd_addr(nfc_cmd_addr),
        .nfc_cmd_wdata(nfc_cmd_wdata),
        .nfc_cmd_rdata(nfc_cmd_rdata),
        .nfc_cmd_done(nfc_cmd_done),
        .detection_error(detection_error),
        .error_code(error_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endfunction

    // Reader model: random ready, one response per accepted command after a set latency.
    initial begin : reader
        resp_t r;
        nfc_cmd_ready = 1'b0;
        nfc_cmd_done  = 1'b0;
        nfc_cmd_rdata = 8'h00;
        forever begin
            @(negedge clk);
            nfc_cmd_done  = 1'b0;
            nfc_cmd_rdata = 8'($urandom);
            nfc_cmd_ready = rst_n && ($urandom_range(0, 3) != 0);
            if (rst_n && nfc_cmd_valid && nfc_cmd_ready) begin
                if (resp_q.size() > 0) r = resp_q.pop_front();
                else begin r.val = -1; r.lat = 0; end
                @(negedge clk);
                nfc_cmd_ready = 1'b0;
                nfc_cmd_rdata = 8'($urandom);
                if (r.val >= 0) begin
                    repeat (r.lat - 1) @(negedge clk);
                    nfc_cmd_done  = 1'b1;
                    nfc_cmd_rdata = 8'(r.val);
                end
            end
        end
    end

    // Monitor: compares each accepted command and each outcome against the scoreboard queues.
    initial begin : monitor
        bit         prev_rdy;
        bit         prev_err;
        int         hold;
        logic [7:0] e;
        logic [7:0] last_code;
        out_t       o;
        prev_rdy  = 0;
        prev_err  = 0;
        hold      = 0;
        last_code = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_rdy = 0;
                prev_err = 0;
                hold     = 0;
                continue;
            end
            if (nfc_cmd_valid && nfc_cmd_ready) begin
                n_xfer++;
                if (exp_cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd actual=%h expected=none", nfc_cmd_wdata);
                end else begin
                    e = exp_cmd_q.pop_front();
                    chk("cmd_byte", 32'(nfc_cmd_wdata), 32'(e));
                end
                chk("cmd_write", 32'(nfc_cmd_write), 32'd1);
                chk("cmd_addr", 32'(nfc_cmd_addr), 32'h09);
            end
            if ((card_ready && !prev_rdy) || (detection_error && !prev_err)) begin
                if (exp_out_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_outcome actual=rdy%0d/err%0d expected=none", card_ready, detection_error);
                end else begin
                    o = exp_out_q.pop_front();
                    last_code = o.code;
                    chk("detection_error", 32'(detection_error), 32'(o.is_err));
                    chk("card_ready", 32'(card_ready), 32'(!o.is_err));
                    chk("start_auth", 32'(start_auth), 32'(!o.is_err));
                    chk("error_code", 32'(error_code), 32'(o.code));
                    chk("card_uid", card_uid, o.uid);
                    chk("card_detected_hold", 32'(card_detected), 32'd1);
                    chk("cmds_outstanding", 32'(exp_cmd_q.size()), 32'd0);
                end
            end
            if (card_ready || detection_error) begin
                hold++;
            end else if (prev_rdy || prev_err) begin
                chk("hold_len", 32'(hold), 32'(HOLD_CYCLES));
                chk("card_detected_clear", 32'(card_detected), 32'd0);
                chk("code_retained", 32'(error_code), 32'(last_code));
                hold = 0;
            end
            prev_rdy = card_ready;
            prev_err = detection_error;
        end
    end

    // Reference model: walk the three exchanges and derive commands, UID and error code.
    task automatic run_trial(input int r0, input int r1, input int r2,
                             input int l0, input int l1, input int l2);
        int   r[3];
        int   l[3];
        int   code;
        logic [31:0] uid;
        out_t o;
        bit   seen;
        r[0] = r0; r[1] = r1; r[2] = r2;
        l[0] = l0; l[1] = l1; l[2] = l2;
        code = 0;
        uid  = 32'h0;
        for (int s = 0; s < 3; s++) begin
            exp_cmd_q.push_back(s == 0 ? 8'h26 : 8'h93);
            resp_q.push_back('{r[s], l[s]});
            if (r[s] < 0 || l[s] > CMD_TIMEOUT) begin code = 'h11 + s; break; end
            if (r[s] == 'hFF) begin code = 'h21 + s; break; end
            if (s == 0 && r[s] == 0) begin code = 'h21; break; end
            if (s == 1) uid = 32'(r[s]);
            if (s == 2 && ((r[s] / 4) % 2) == 1) begin code = 'h24; break; end
        end
        o.is_err = (code != 0);
        o.code   = 8'(code);
        o.uid    = uid;
        exp_out_q.push_back(o);

        @(negedge clk);
        nfc_irq = 1'b1;
        @(negedge clk);
        chk("start_latency_c1", 32'(card_detected), 32'd0);
        @(negedge clk);
        chk("start_latency_c2", 32'(card_detected), 32'd1);

        seen = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (card_ready || detection_error) begin
                nfc_irq = 1'b0;
                seen = 1;
                break;
            end
            if (c >= 7 && $urandom_range(0, 3) == 0) nfc_irq = ~nfc_irq;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL outcome_timeout actual=none expected=outcome");
            nfc_irq = 1'b0;
        end
        seen = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!card_detected) begin seen = 1; break; end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy expected=idle");
        end
        repeat ($urandom_range(2, 5)) @(negedge clk);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int  rr[3];
        int  ll[3];
        int  p;
        int  base;
        bit  reached;
        bit  bad;
        rst_n   = 1'b0;
        nfc_irq = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_card_detected", 32'(card_detected), 32'd0);
        chk("rst_card_uid", card_uid, 32'h0);
        chk("rst_card_ready", 32'(card_ready), 32'd0);
        chk("rst_start_auth", 32'(start_auth), 32'd0);
        chk("rst_cmd_valid", 32'(nfc_cmd_valid), 32'd0);
        chk("rst_cmd_write", 32'(nfc_cmd_write), 32'd0);
        chk("rst_cmd_addr", 32'(nfc_cmd_addr), 32'h09);
        chk("rst_cmd_wdata", 32'(nfc_cmd_wdata), 32'h00);
        chk("rst_detection_error", 32'(detection_error), 32'd0);
        chk("rst_error_code", 32'(error_code), 32'h00);

        run_trial('h04, 'h78, 'h08, 7, 7, 7);
        run_trial('h04, 'h78, 'h08, 7, 7, 7);
        run_trial('hFF, 0, 0, 7, 7, 7);
        run_trial('h04, 'h78, 'h04, 7, 7, 7);
        run_trial('h04, -1, 0, 7, 0, 7);
        run_trial('h00, 0, 0, 3, 3, 3);
        run_trial('h44, 'hFF, 0, 2, 2, 2);
        run_trial('h44, 'h12, 'hFF, 2, 2, 2);
        run_trial(-1, 0, 0, 0, 0, 0);
        run_trial('h44, 'h00, -1, 1, 1, 0);
        run_trial('h04, 'h5A, 'h20, CMD_TIMEOUT, CMD_TIMEOUT, CMD_TIMEOUT);
        run_trial('h04, 'h5A, 'h20, CMD_TIMEOUT + 1, 1, 1);
        run_trial('h04, 'h78, 'h08, 7, 7, 7);

        for (int t = 0; t < 40; t++) begin
            for (int s = 0; s < 3; s++) begin
                p     = $urandom_range(0, 9);
                ll[s] = $urandom_range(1, 12);
                case (p)
                    0:       rr[s] = -1;
                    1:       rr[s] = 'hFF;
                    2:       rr[s] = 'h00;
                    default: rr[s] = $urandom_range(0, 255);
                endcase
                if (s == 2 && p >= 3 && $urandom_range(0, 3) != 0) rr[s] = rr[s] & 'hFB;
                if ($urandom_range(0, 19) == 0) ll[s] = CMD_TIMEOUT + $urandom_range(0, 1);
            end
            run_trial(rr[0], rr[1], rr[2], ll[0], ll[1], ll[2]);
        end

        base = n_xfer;
        exp_cmd_q.push_back(8'h26);
        exp_cmd_q.push_back(8'h93);
        exp_cmd_q.push_back(8'h93);
        resp_q.push_back('{'h04, 3});
        resp_q.push_back('{'h78, 3});
        resp_q.push_back('{-1, 0});
        @(negedge clk);
        nfc_irq = 1'b1;
        reached = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (n_xfer >= base + 3) begin reached = 1; break; end
        end
        if (!reached) begin
            checks++;
            errors++;
            $display("FAIL select_reach actual=%0d expected=%0d", n_xfer - base, 3);
        end
        repeat (4) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_card_detected", 32'(card_detected), 32'd0);
        chk("arst_card_uid", card_uid, 32'h0);
        chk("arst_card_ready", 32'(card_ready), 32'd0);
        chk("arst_start_auth", 32'(start_auth), 32'd0);
        chk("arst_cmd_valid", 32'(nfc_cmd_valid), 32'd0);
        chk("arst_cmd_wdata", 32'(nfc_cmd_wdata), 32'h00);
        chk("arst_detection_error", 32'(detection_error), 32'd0);
        chk("arst_error_code", 32'(error_code), 32'h00);
        chk("arst_cmds_outstanding", 32'(exp_cmd_q.size()), 32'd0);
        @(negedge clk);
        nfc_irq = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (nfc_cmd_valid || card_detected) bad = 1;
        end
        chk("no_reissue_after_reset", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
